program_counter_stack: RTL and testbench

PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

---
 rtl/program_counter_stack.sv | 80 ++++++++
 tb/tb_program_counter_stack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// Program counter with a small return-address stack for call/ret.
// All state advances on the falling CLK edge; CLR clears everything asynchronously.
module program_counter_stack #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 2,
  parameter int WRAP        = 0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              Cp,
  input  logic              Ep,
  input  logic              Lp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] proximo_endereco,
  output logic [ADDR_W-1:0] endereco_atual,
  output logic              halt,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ONES   = '1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [PTR_W-1:0]  occ;
  logic              err;
  // Entry 0 is always the top of stack; push/pop shift the whole array.
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  always_comb begin
    pc_next_seq = pc + ADDR_W'(1);
    if ((WRAP == 0) && (pc == ONES)) pc_next_seq = pc;
  end

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      pc  <= '0;
      occ <= '0;
      err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else if (call && ret) begin
      err <= 1'b1;
    end else if (ret) begin
      if (occ == '0) begin
        err <= 1'b1;
      end else begin
        pc  <= stack_mem[0];
        occ <= occ - ONE_P;
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack_mem[i] <= stack_mem[i+1];
      end
    end else if (call) begin
      if (occ == DEPTH_C) begin
        err <= 1'b1;
      end else begin
        for (int i = STACK_DEPTH - 1; i > 0; i--) stack_mem[i] <= stack_mem[i-1];
        stack_mem[0] <= pc_next_seq;
        pc  <= jump_addr;
        occ <= occ + ONE_P;
      end
    end else if (Lp) begin
      pc <= jump_addr;
    end else if (Cp) begin
      pc <= pc_next_seq;
    end
  end

  assign proximo_endereco = Ep ? pc : '0;
  assign endereco_atual   = pc;
  assign halt             = (WRAP == 0) && (pc == ONES);
  assign stack_full       = (occ == DEPTH_C);
  assign stack_empty      = (occ == '0);
  assign stack_err        = err;

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench: two instances (saturating and wrapping) share stimulus and
// are compared against a queue-based reference model of the PC and stack.
module tb_program_counter_stack;

  localparam int AW = 4;
  localparam int DEPTH = 2;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic Cp = 0, Ep = 0, Lp = 0, call = 0, ret = 0;
  logic [AW-1:0] jump_addr = '0;

  logic [AW-1:0] prox_s, cur_s, prox_w, cur_w;
  logic halt_s, full_s, empty_s, err_s;
  logic halt_w, full_w, empty_w, err_w;

  program_counter_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .WRAP(0)) u_sat (
    .CLK(CLK), .CLR(CLR), .Cp(Cp), .Ep(Ep), .Lp(Lp), .call(call), .ret(ret),
    .jump_addr(jump_addr), .proximo_endereco(prox_s), .endereco_atual(cur_s),
    .halt(halt_s), .stack_full(full_s), .stack_empty(empty_s), .stack_err(err_s));

  program_counter_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .WRAP(1)) u_wrap (
    .CLK(CLK), .CLR(CLR), .Cp(Cp), .Ep(Ep), .Lp(Lp), .call(call), .ret(ret),
    .jump_addr(jump_addr), .proximo_endereco(prox_w), .endereco_atual(cur_w),
    .halt(halt_w), .stack_full(full_w), .stack_empty(empty_w), .stack_err(err_w));

  always #5 CLK = ~CLK;

  typedef struct {
    int pc;
    int prox;
    int full;
    int empty;
    int err;
    int halt;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];

  int passed = 0;
  int total  = 0;

  // Reference model: index 0 = saturating, 1 = wrapping
  int m_pc [2];
  int m_err[2];
  int m_stk[2][$];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
  endtask

  function automatic int nxt(input int w, input int pc);
    if (w == 1) return (pc + 1) % 16;
    return (pc == 15) ? 15 : pc + 1;
  endfunction

  function automatic exp_t snapshot(input int w, input logic ep);
    exp_t e;
    e.pc    = m_pc[w];
    e.prox  = ep ? m_pc[w] : 0;
    e.full  = (m_stk[w].size() == DEPTH) ? 1 : 0;
    e.empty = (m_stk[w].size() == 0) ? 1 : 0;
    e.err   = m_err[w];
    e.halt  = (w == 0 && m_pc[w] == 15) ? 1 : 0;
    return e;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_pc[w] = 0;
      m_err[w] = 0;
      m_stk[w].delete();
    end
  endtask

  task automatic model_step(input logic c, input logic r, input logic l,
                            input logic p, input int ja);
    for (int w = 0; w < 2; w++) begin
      if (c && r) m_err[w] = 1;
      else if (r) begin
        if (m_stk[w].size() > 0) m_pc[w] = m_stk[w].pop_back();
        else m_err[w] = 1;
      end else if (c) begin
        if (m_stk[w].size() < DEPTH) begin
          m_stk[w].push_back(nxt(w, m_pc[w]));
          m_pc[w] = ja;
        end else m_err[w] = 1;
      end else if (l) m_pc[w] = ja;
      else if (p) m_pc[w] = nxt(w, m_pc[w]);
    end
  endtask

  // One falling-edge action: drive after the rising edge, expectation queued.
  task automatic drive(input logic c, input logic r, input logic l,
                       input logic p, input logic e, input int ja);
    @(posedge CLK);
    #1;
    CLR = 0; call = c; ret = r; Lp = l; Cp = p; Ep = e; jump_addr = AW'(ja);
    model_step(c, r, l, p, ja);
    q_s.push_back(snapshot(0, e));
    q_w.push_back(snapshot(1, e));
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    CLR = 1;
    call = 1'($urandom); ret = 1'($urandom); Lp = 1; Cp = 1; Ep = 1;
    jump_addr = AW'($urandom_range(0, 15));
    #1;
    chk("rst_async_pc_s", int'(cur_s), 0);
    chk("rst_async_pc_w", int'(cur_w), 0);
    chk("rst_async_prox_s", int'(prox_s), 0);
    chk("rst_async_empty_s", int'(empty_s), 1);
    chk("rst_async_full_w", int'(full_w), 0);
    chk("rst_async_err_s", int'(err_s), 0);
    chk("rst_async_halt_s", int'(halt_s), 0);
    model_reset();
    q_s.push_back(snapshot(0, 1'b1));
    q_w.push_back(snapshot(1, 1'b1));
  endtask

  // Monitor: outputs settled after the falling edge are sampled on the rising edge.
  always @(posedge CLK) begin
    if (q_s.size() > 0) begin
      exp_t e;
      e = q_s.pop_front();
      chk("sat_pc", int'(cur_s), e.pc);
      chk("sat_prox", int'(prox_s), e.prox);
      chk("sat_full", int'(full_s), e.full);
      chk("sat_empty", int'(empty_s), e.empty);
      chk("sat_err", int'(err_s), e.err);
      chk("sat_halt", int'(halt_s), e.halt);
    end
    if (q_w.size() > 0) begin
      exp_t e;
      e = q_w.pop_front();
      chk("wrap_pc", int'(cur_w), e.pc);
      chk("wrap_prox", int'(prox_w), e.prox);
      chk("wrap_full", int'(full_w), e.full);
      chk("wrap_empty", int'(empty_w), e.empty);
      chk("wrap_err", int'(err_w), e.err);
      chk("wrap_halt", int'(halt_w), e.halt);
    end
  end

  initial begin
    int budget;
    model_reset();
    #2;
    chk("init_pc", int'(cur_s), 0);
    chk("init_empty", int'(empty_s), 1);

    // Count up to saturation / wrap-around
    pulse_reset();
    for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 1, 3);
    drive(0, 0, 1, 0, 1, 14);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 0);

    // Nested call/return
    pulse_reset();
    drive(0, 0, 1, 0, 1, 5);
    drive(1, 0, 0, 0, 1, 9);
    drive(1, 0, 0, 0, 1, 12);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);

    // Misuse: overflow, underflow, simultaneous call/ret
    drive(1, 0, 0, 0, 1, 9);
    drive(1, 0, 0, 0, 1, 12);
    drive(1, 0, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 4);
    drive(0, 0, 0, 1, 1, 0);

    // Return address pushed at all-ones
    pulse_reset();
    drive(0, 0, 1, 0, 1, 15);
    drive(1, 0, 0, 0, 1, 2);
    drive(0, 1, 0, 0, 1, 0);

    // Output enable only; no state change
    drive(0, 0, 1, 0, 0, 6);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1'(i), 11);

    // Async reset while one entry stacked
    drive(0, 0, 1, 0, 1, 3);
    drive(1, 0, 0, 0, 1, 7);
    pulse_reset();
    drive(0, 1, 0, 0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom),
                 1'($urandom), $urandom_range(0, 15));
    end

    budget = 0;
    while ((q_s.size() > 0 || q_w.size() > 0) && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    chk("scoreboard_drained", q_s.size() + q_w.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
